// File: rtl/rvfi_trace_pkg.sv
// Shared constants and helpers for the RVFI trace buffer.
package rvfi_trace_pkg;

  localparam logic [7:0]  TRACE_HEADER = 8'h7E;
  localparam int unsigned FRAME_BYTES  = 14;

  localparam int unsigned FLAG_TRAP = 7;
  localparam int unsigned FLAG_DROP = 6;

  // Record layout: {trap, pc, insn, rd_addr, rd_wdata, dropped}
  localparam int unsigned REC_W         = 1 + 1 + 32 + 32 + 5 + 32;
  localparam int unsigned REC_DROP_LSB  = 0;
  localparam int unsigned REC_WDATA_LSB = 1;
  localparam int unsigned REC_RD_LSB    = 33;
  localparam int unsigned REC_INSN_LSB  = 38;
  localparam int unsigned REC_PC_LSB    = 70;
  localparam int unsigned REC_TRAP_LSB  = 102;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_LOAD,
    SER_SEND
  } ser_state_t;

  // Byte idx of the serialized frame for a stored record.
  function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec,
                                            input logic [3:0]       idx);
    logic [7:0]               flags;
    logic [8*FRAME_BYTES-1:0] frame;
    flags            = '0;
    flags[FLAG_TRAP] = rec[REC_TRAP_LSB];
    flags[FLAG_DROP] = rec[REC_DROP_LSB];
    flags[4:0]       = rec[REC_RD_LSB +: 5];
    frame = {flags,
             rec[REC_WDATA_LSB +: 32],
             rec[REC_INSN_LSB +: 32],
             rec[REC_PC_LSB +: 32],
             TRACE_HEADER};
    return frame[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Synchronous FIFO with registered read data.
// push/pop are ignored when full/empty respectively; count ranges 0..DEPTH.
module rvfi_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement capture: queues records and emits 14-byte frames on a
// byte-wide valid/ready stream; raises stall_req near full, counts drops.
module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rvfi_valid,
  input  logic                   rvfi_trap,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [31:0]            rvfi_insn,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic [31:0]            rvfi_rd_wdata,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   stall_req,
  output logic [15:0]            drop_count,
  output logic [$clog2(DEPTH):0] fifo_count
);

  ser_state_t       state;
  logic [REC_W-1:0] frame_q;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] rd_rec;
  logic [3:0]       idx;
  logic             dropped_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_fire;
  logic             pop_fire;
  logic             drop_ev;
  logic             stall_next;
  int unsigned      cnt_next;

  // Full is judged on occupancy before any same-edge pop.
  assign push_fire = enable && rvfi_valid && !fifo_full;
  assign drop_ev   = enable && rvfi_valid && fifo_full;
  assign pop_fire  = (state == SER_IDLE) && !fifo_empty;
  assign wr_rec    = {rvfi_trap, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr,
                      rvfi_rd_wdata, dropped_q};

  rvfi_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_fire),
    .wr_data (wr_rec),
    .pop     (pop_fire),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    cnt_next = 32'(fifo_count);
    if (push_fire) cnt_next = cnt_next + 1;
    if (pop_fire)  cnt_next = cnt_next - 1;
    stall_next = (DEPTH - cnt_next) <= STALL_MARGIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      dropped_q  <= 1'b0;
      stall_req  <= 1'b0;
    end else begin
      if (drop_ev && drop_count != '1) begin
        drop_count <= drop_count + 16'd1;
      end
      if (push_fire) begin
        dropped_q <= 1'b0;
      end else if (drop_ev) begin
        dropped_q <= 1'b1;
      end
      stall_req <= stall_next;
    end
  end

  // tx_data is preloaded with the next byte on each accept so the stream
  // stays registered and holds steady under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SER_IDLE;
      frame_q  <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (!fifo_empty) begin
            state <= SER_LOAD;
          end
        end
        SER_LOAD: begin
          frame_q  <= rd_rec;
          idx      <= '0;
          tx_valid <= 1'b1;
          tx_data  <= TRACE_HEADER;
          state    <= SER_SEND;
        end
        SER_SEND: begin
          if (tx_ready) begin
            if (idx == 4'(FRAME_BYTES - 1)) begin
              tx_valid <= 1'b0;
              state    <= SER_IDLE;
            end else begin
              idx     <= idx + 4'd1;
              tx_data <= frame_byte(frame_q, idx + 4'd1);
            end
          end
        end
        default: begin
          state    <= SER_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
